cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Sequences instruction fetch and gates the decoder
//  (drives its en_i and latched instruction). Issues data-memory handshakes for LW/SW.
//  Pulses register-file and PC writes once per retired instruction.
//  Traps on illegal, ECALL/EBREAK and bus timeout. Sits between the instruction/data bus and the decoder/RF/PC.
// PARAMETERS
//  TIMEOUT    16  max wait cycles for imem/dmem ack before trap; 0 = timeout disabled
//  INSTRET_W  32  width of retired-instruction counter
// PORTS
//  clk_i           in   1          system clock
//  rst_i           in   1          asynchronous active-high reset
//  halt_i          in   1          debug halt request; sampled in IDLE and WB
//  imem_req_o      out  1          instruction fetch request
//  imem_ack_i      in   1          fetch data valid on imem_data_i
//  imem_data_i     in   32         fetched instruction
//  ir_o            out  32         latched instruction, feeds decoder instr_i
//  dec_en_o        out  1          decoder enable
//  dec_d_we_i      in   1          decoder d_we_o (store)
//  dec_reg_en_i    in   1          decoder reg_in_en_o
//  dmem_req_o      out  1          data access request
//  dmem_we_o       out  1          data write strobe, valid with dmem_req_o
//  dmem_ack_i      in   1          data access complete
//  rf_we_o         out  1          RF write pulse
//  pc_we_o         out  1          PC update pulse
//  trap_o          out  1          core halted on trap, sticky until reset
//  trap_cause_o    out  3          0 none,1 illegal,2 imem timeout,3 dmem timeout,4 ecall/ebreak
//  instret_o       out  INSTRET_W  retired instruction count
//  state_o         out  3          current FSM state (debug)
// BEHAVIOUR
//  Reset: state=IDLE; ir_o=0, instret_o=0, trap_cause_o=0; all req/we/en/trap outputs 0.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
//  IDLE: halt_i=0 -> FETCH next cycle.
//  FETCH: imem_req_o=1 held until imem_ack_i. On ack, ir_o<=imem_data_i -> DECODE.
//  DECODE: dec_en_o=1. Classify ir_o[6:0]:
//   - illegal opcode -> TRAP(1);
//   - SYSTEM -> TRAP(4);
//   - LOAD/STORE with funct3!=010 -> TRAP(1);
//   - else EXEC.
//  EXEC: dec_en_o=1. LOAD/STORE -> MEM; all others (incl. FENCE as NOP) -> WB.
//  MEM: dec_en_o=1; dmem_req_o=1, dmem_we_o=dec_d_we_i, held until dmem_ack_i -> WB.
//  WB: dec_en_o=1; rf_we_o=dec_reg_en_i; pc_we_o=1; instret_o+=1 (wraps modulo 2^INSTRET_W).
//   Next: IDLE if halt_i else FETCH.
//  TRAP: trap_o=1, cause held; all req/we/en 0; exits only via rst_i.
//  Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
//   When count==TIMEOUT-1 with no ack -> TRAP(2 in FETCH, 3 in MEM).
//   Ack and timeout in the same cycle: ack wins.
//  Acks outside the matching req state are ignored. ir_o is stable from DECODE through WB.
//  Latency, zero-wait bus: non-mem instr 4 cycles (FETCH,DECODE,EXEC,WB); LW/SW 5 cycles.
//  rf_we_o/pc_we_o are single-cycle pulses, never asserted outside WB.
//  halt_i never aborts an instruction in flight; it is honoured only at the IDLE/WB boundary.
//  Reset mid-transaction drops req immediately (async); the bus must tolerate an abandoned request.
// STRUCTURE
//  cpu_pkg: seq_state_t enum, trap_cause_t enum, RV32I opcode localparams (OP_LUI..OP_SYSTEM).
//  Sub-module instr_classifier (combinational): ir -> {legal, is_mem, is_system}.
//  One registered FSM plus wait counter and instret counter in cpu_sequencer.
// TESTING
//  ADDI x1,x0,5 (0x00500093), ack same cycle -> rf_we_o and pc_we_o pulse at cycle 4;
//   instret_o=1; ack delayed 3 cycles -> pulses at cycle 7.
//  SW (0x0020A023), dmem ack delayed 2 -> dmem_req_o=1 and dmem_we_o=1 for 3 cycles;
//   rf_we_o=0, pc_we_o=1 pulse; 5+2 cycles total.
//  Opcode 0x7F, or LB (funct3=000) -> trap_o=1, cause=1; no further imem_req_o.
//   ECALL 0x00000073 -> cause=4.
//  imem_ack_i held low, TIMEOUT=16 -> trap cause=2 after 16 req cycles.
//   Ack on the 16th cycle -> no trap.
//  halt_i raised during MEM -> instruction retires, FSM parks in IDLE.
//   Drop halt_i -> FETCH next cycle.
//  rst_i pulsed mid-MEM -> all outputs 0 same cycle; instret_o=0; restart from IDLE.
//   Preload instret at 2^32-1 (force) -> wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer state and trap-cause enums, RV32I major opcodes and classification helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } seq_state_t;

    typedef enum logic [2:0] {
        TC_NONE    = 3'd0,
        TC_ILLEGAL = 3'd1,
        TC_IMEM_TO = 3'd2,
        TC_DMEM_TO = 3'd3,
        TC_ECALL   = 3'd4
    } trap_cause_t;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Only word accesses are supported by the data bus.
    localparam logic [2:0] F3_WORD = 3'b010;

    function automatic logic known_opcode(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                          OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM};
    endfunction

endpackage

// File: rtl/instr_classifier.sv
// instr_classifier: combinational opcode/funct3 check feeding the sequencer's DECODE decision.
module instr_classifier
    import cpu_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    output logic       legal,
    output logic       is_mem,
    output logic       is_system
);

    assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    assign is_system = op == OP_SYSTEM;
    assign legal     = known_opcode(op) && !(is_mem && funct3 != F3_WORD);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle RV32I control FSM sequencing fetch, decode, data access and retire,
// with bus-timeout and illegal/system traps.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 halt_i,
    output logic                 imem_req_o,
    input  logic                 imem_ack_i,
    input  logic [31:0]          imem_data_i,
    output logic [31:0]          ir_o,
    output logic                 dec_en_o,
    input  logic                 dec_d_we_i,
    input  logic                 dec_reg_en_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ack_i,
    output logic                 rf_we_o,
    output logic                 pc_we_o,
    output logic                 trap_o,
    output logic [2:0]           trap_cause_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic [2:0]           state_o
);

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    seq_state_t  state, state_n;
    trap_cause_t cause, cause_n;
    logic [CW-1:0] wait_cnt;
    logic legal, is_mem, is_system, to_hit;

    instr_classifier u_cls (
        .op        (ir_o[6:0]),
        .funct3    (ir_o[14:12]),
        .legal     (legal),
        .is_mem    (is_mem),
        .is_system (is_system)
    );

    assign to_hit       = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
    assign state_o      = state;
    assign trap_cause_o = cause;

    // An ack always takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_n = state;
        cause_n = cause;
        case (state)
            S_IDLE:   state_n = halt_i ? S_IDLE : S_FETCH;
            S_FETCH:  if (imem_ack_i) state_n = S_DECODE;
                      else if (to_hit) begin state_n = S_TRAP; cause_n = TC_IMEM_TO; end
            S_DECODE: if (!legal) begin state_n = S_TRAP; cause_n = TC_ILLEGAL; end
                      else if (is_system) begin state_n = S_TRAP; cause_n = TC_ECALL; end
                      else state_n = S_EXEC;
            S_EXEC:   state_n = is_mem ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack_i) state_n = S_WB;
                      else if (to_hit) begin state_n = S_TRAP; cause_n = TC_DMEM_TO; end
            S_WB:     state_n = halt_i ? S_IDLE : S_FETCH;
            default:  state_n = S_TRAP;
        endcase
    end

    // Outputs are registered from the next state so each one is glitch-free for its whole state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cause      <= TC_NONE;
            wait_cnt   <= '0;
            ir_o       <= '0;
            instret_o  <= '0;
            imem_req_o <= 1'b0;
            dec_en_o   <= 1'b0;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            rf_we_o    <= 1'b0;
            pc_we_o    <= 1'b0;
            trap_o     <= 1'b0;
        end else begin
            state      <= state_n;
            cause      <= cause_n;
            wait_cnt   <= (state_n != state) ? '0 : wait_cnt + 1'b1;
            if (state == S_FETCH && imem_ack_i) ir_o <= imem_data_i;
            if (state == S_WB) instret_o <= instret_o + 1'b1;
            imem_req_o <= state_n == S_FETCH;
            dec_en_o   <= state_n inside {S_DECODE, S_EXEC, S_MEM, S_WB};
            dmem_req_o <= state_n == S_MEM;
            dmem_we_o  <= (state_n == S_MEM) && dec_d_we_i;
            rf_we_o    <= (state_n == S_WB) && dec_reg_en_i;
            pc_we_o    <= state_n == S_WB;
            trap_o     <= state_n == S_TRAP;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench; retire expectations are queued at fetch and checked at WB.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] SW    = 32'h0020_A023;
    localparam logic [31:0] LW    = 32'h0000_A103;
    localparam logic [31:0] LB    = 32'h0000_8083;
    localparam logic [31:0] BAD   = 32'h0000_007F;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk_i = 0, rst_i = 1, halt_i = 0;
    logic        imem_ack_i = 0, dmem_ack_i = 0, dec_d_we_i = 0, dec_reg_en_i = 0;
    logic [31:0] imem_data_i = '0;
    logic        imem_req_o, dec_en_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, trap_o;
    logic [31:0] ir_o, instret_o;
    logic [2:0]  trap_cause_o, state_o;

    typedef struct {
        int          wb;
        logic        rf;
        logic [31:0] ir;
        logic [31:0] ic;
    } ret_t;

    ret_t        exp_q[$];
    logic [31:0] exp_instret = '0;
    int          cyc = 0, n_chk = 0, n_fail = 0;

    cpu_sequencer #(.TIMEOUT(16), .INSTRET_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .halt_i(halt_i),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .ir_o(ir_o), .dec_en_o(dec_en_o), .dec_d_we_i(dec_d_we_i), .dec_reg_en_i(dec_reg_en_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
        .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
        .instret_o(instret_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin : mon
        ret_t e;
        if (!rst_i) begin
            if (rf_we_o && !pc_we_o) check("rf_we_outside_wb", 1, 0);
            if (pc_we_o) begin
                if (exp_q.size() == 0) check("unexpected_retire", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("wb_cycle", cyc, e.wb);
                    check("wb_rf_we", rf_we_o, e.rf);
                    check("wb_ir", ir_o, e.ir);
                    check("wb_dec_en", dec_en_o, 1);
                    check("wb_instret", instret_o, e.ic);
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1;
        imem_ack_i = 0;
        dmem_ack_i = 0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        check("rst_ctrl", {imem_req_o, dmem_req_o, dmem_we_o, dec_en_o, rf_we_o, pc_we_o, trap_o}, 0);
        check("rst_state", state_o, S_IDLE);
        check("rst_ir", ir_o, 0);
        check("rst_instret", instret_o, 0);
        check("rst_cause", trap_cause_o, 0);
        rst_i = 0;
        exp_instret = '0;
    endtask

    task automatic wait_req(output int start);
        int n = 0;
        while (!imem_req_o && n < 20) begin @(negedge clk_i); n++; end
        check("req_seen", imem_req_o, 1);
        start = cyc;
    endtask

    task automatic fetch(input logic [31:0] ins, input int id);
        repeat (id) @(negedge clk_i);
        imem_ack_i = 1;
        imem_data_i = ins;
        @(negedge clk_i);
        imem_ack_i = 0;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int id, input bit mem, input int dd,
                            input bit st, input bit reg_en, input bit hlt);
        int start, n, cnt;
        wait_req(start);
        dec_d_we_i = st;
        dec_reg_en_i = reg_en;
        exp_q.push_back('{wb: start + 3 + id + (mem ? dd + 1 : 0), rf: reg_en, ir: ins, ic: exp_instret});
        exp_instret++;
        fetch(ins, id);
        if (mem) begin
            n = 0;
            while (!dmem_req_o && n < 10) begin @(negedge clk_i); n++; end
            if (hlt) halt_i = 1;
            cnt = 0;
            repeat (dd) begin
                if (dmem_req_o && dmem_we_o == st) cnt++;
                @(negedge clk_i);
            end
            if (dmem_req_o && dmem_we_o == st) cnt++;
            dmem_ack_i = 1;
            @(negedge clk_i);
            dmem_ack_i = 0;
            check("dmem_req_cycles", cnt, dd + 1);
        end
        n = 0;
        while (!pc_we_o && n < 10) begin @(negedge clk_i); n++; end
        check("retire_seen", pc_we_o, 1);
        @(negedge clk_i);
    endtask

    task automatic trap_case(input string tag, input logic [31:0] ins, input logic [2:0] cause);
        int start;
        wait_req(start);
        fetch(ins, 0);
        @(negedge clk_i);
        check({tag, "_trap"}, trap_o, 1);
        check({tag, "_cause"}, trap_cause_o, cause);
        repeat (4) @(negedge clk_i);
        check({tag, "_quiet"}, {imem_req_o, dmem_req_o, dec_en_o, pc_we_o, trap_o}, 5'b00001);
        check({tag, "_state"}, state_o, S_TRAP);
        do_reset();
    endtask

    task automatic count_to_trap(input string tag, input logic [2:0] cause);
        int cnt = 0;
        while (!trap_o && cnt < 40) begin
            if (imem_req_o || dmem_req_o) cnt++;
            @(negedge clk_i);
        end
        check({tag, "_cycles"}, cnt, 16);
        check({tag, "_cause"}, trap_cause_o, cause);
        do_reset();
    endtask

    initial begin
        int start, n;
        do_reset();
        do_instr(ADDI, 0, 0, 0, 0, 1, 0);
        check("instret_1", instret_o, 1);
        do_instr(ADDI, 3, 0, 0, 0, 1, 0);
        do_instr(SW, 0, 1, 2, 1, 0, 0);
        do_instr(LW, 0, 1, 0, 0, 1, 0);
        do_instr(ADDI, 15, 0, 0, 0, 1, 0);
        check("ack_beats_timeout", trap_o, 0);
        do_instr(LW, 1, 1, 1, 0, 1, 1);
        repeat (3) @(negedge clk_i);
        check("halt_parked", {state_o, imem_req_o}, {S_IDLE, 1'b0});
        halt_i = 0;
        @(negedge clk_i);
        check("halt_release", {state_o, imem_req_o}, {S_FETCH, 1'b1});
        force dut.instret_o = 32'hFFFF_FFFF;
        #1 release dut.instret_o;
        exp_instret = 32'hFFFF_FFFF;
        do_instr(ADDI, 0, 0, 0, 0, 1, 0);
        check("instret_wrap", instret_o, 0);
        wait_req(start);
        dec_d_we_i = 1;
        fetch(SW, 0);
        n = 0;
        while (!dmem_req_o && n < 10) begin @(negedge clk_i); n++; end
        check("mid_mem_we", dmem_we_o, 1);
        #1 rst_i = 1;
        #1 check("async_rst_outputs", {imem_req_o, dmem_req_o, dmem_we_o, dec_en_o, pc_we_o, trap_o, state_o}, 0);
        check("async_rst_instret", instret_o, 0);
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 0;
        exp_instret = '0;
        @(negedge clk_i);
        check("restart_fetch", imem_req_o, 1);
        do_instr(ADDI, 0, 0, 0, 0, 1, 0);
        check("restart_instret", instret_o, 1);
        trap_case("illegal", BAD, TC_ILLEGAL);
        trap_case("lb", LB, TC_ILLEGAL);
        trap_case("ecall", ECALL, TC_ECALL);
        wait_req(start);
        count_to_trap("imem_to", TC_IMEM_TO);
        wait_req(start);
        dec_d_we_i = 0;
        fetch(LW, 0);
        n = 0;
        while (!dmem_req_o && n < 10) begin @(negedge clk_i); n++; end
        count_to_trap("dmem_to", TC_DMEM_TO);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
